pipelined_shift_unit: RTL and testbench

- Parametrised, pipelined barrel shifter that succeeds the 8-bit combinational logical shifter in the ALU datapath.
- Adds configurable data width, explicit mode select (logical left, logical right, arithmetic right, rotate right) and defined behaviour for over-range shift amounts.
- One log2 shift stage is registered per cycle, with valid/ready handshakes on input and output, so it can sit between the register-file read and the writeback mux of a multi-cycle or pipelined core.

---
 rtl/pipelined_shift_unit_if.sv | 29 ++
 rtl/pipelined_shift_unit.sv | 140 ++++++++++++++
 tb/tb_pipelined_shift_unit.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_shift_unit_if.sv
// Handshake bundle for pipelined_shift_unit.
// Upstream side: in_valid/in_ready with operand, amount and mode.
// Downstream side: out_valid/out_ready with result data and zero flag.
// master: producer/consumer side (testbench or surrounding core).
// slave:  the shift unit itself.
interface pipelined_shift_unit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface

// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROR over a WIDTH-bit operand.
// One power-of-two shift stage per cycle, valid/ready on both sides, result
// emitted log2(WIDTH) cycles after the accepting edge when not stalled.
// Ports:
//   CLK    - clock, rising edge
//   RESET  - asynchronous active-low reset
//   bus_io - slave side of pipelined_shift_unit_if (in_* request, out_* result)
module pipelined_shift_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 8
) (
    input logic                   CLK,
    input logic                   RESET,
    pipelined_shift_unit_if.slave bus_io
);
    localparam int unsigned STAGES = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ModeSll = 2'b00,
        ModeSrl = 2'b01,
        ModeSra = 2'b10,
        ModeRor = 2'b11
    } mode_e;

    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;

    assign in_data = bus_io.in_data;
    assign in_amt  = bus_io.in_amt;

    // Level k holds an operand with stages 0..k-1 applied; level 0 is the capture register.
    // The amount is shifted down each level so stage k always tests bit 0 of its amount.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] over_q, over_d;
    logic [STAGES-1:0] sign_q, sign_d;
    logic [WIDTH-1:0]  data_q  [STAGES];
    logic [WIDTH-1:0]  data_d  [STAGES];
    logic [WIDTH-1:0]  shifted [STAGES];
    mode_e             mode_q  [STAGES];
    mode_e             mode_d  [STAGES];
    logic [STAGES-1:0] amt_q   [STAGES];
    logic [STAGES-1:0] amt_d   [STAGES];

    logic             out_valid_q, out_valid_d;
    logic             out_zero_q, out_zero_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] res_data;
    logic             stall;

    function automatic logic [WIDTH-1:0] shift_pow2(
        input logic [WIDTH-1:0] d,
        input mode_e            mode,
        input logic             sign,
        input int unsigned      sh
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        // Ones in the MSB positions vacated by a right shift of sh.
        fill = ~({WIDTH{1'b1}} >> sh);
        case (mode)
            ModeSll: r = d << sh;
            ModeSrl: r = d >> sh;
            ModeSra: r = (d >> sh) | (sign ? fill : '0);
            default: r = (d >> sh) | (d << (WIDTH - sh));
        endcase
        return r;
    endfunction

    always_comb begin
        stall = out_valid_q && !bus_io.out_ready;

        for (int unsigned k = 0; k < STAGES; k++) begin
            shifted[k] = amt_q[k][0] ? shift_pow2(data_q[k], mode_q[k], sign_q[k], 32'd1 << k)
                                     : data_q[k];
        end

        // Capture; only loaded when not stalled, so in_ready is implied high.
        vld_d[0]  = bus_io.in_valid;
        data_d[0] = in_data;
        mode_d[0] = mode_e'(bus_io.in_mode);
        amt_d[0]  = in_amt[STAGES-1:0];
        over_d[0] = |(in_amt >> STAGES);
        sign_d[0] = in_data[WIDTH-1];

        for (int unsigned k = 1; k < STAGES; k++) begin
            vld_d[k]  = vld_q[k-1];
            data_d[k] = shifted[k-1];
            mode_d[k] = mode_q[k-1];
            amt_d[k]  = amt_q[k-1] >> 1;
            over_d[k] = over_q[k-1];
            sign_d[k] = sign_q[k-1];
        end

        res_data = shifted[STAGES-1];
        if (over_q[STAGES-1]) begin
            case (mode_q[STAGES-1])
                ModeSll, ModeSrl: res_data = '0;
                ModeSra:          res_data = {WIDTH{sign_q[STAGES-1]}};
                default:          res_data = shifted[STAGES-1]; // ROR: amt mod WIDTH
            endcase
        end

        out_valid_d = vld_q[STAGES-1];
        out_data_d  = res_data;
        out_zero_d  = (res_data == '0);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld_q       <= '0;
            over_q      <= '0;
            sign_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                mode_q[k] <= ModeSll;
                amt_q[k]  <= '0;
            end
        end else if (!stall) begin
            vld_q       <= vld_d;
            over_q      <= over_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
                mode_q[k] <= mode_d[k];
                amt_q[k]  <= amt_d[k];
            end
        end
    end

    assign bus_io.in_ready  = !stall;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_zero  = out_zero_q;
endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Self-checking bench for pipelined_shift_unit at WIDTH=8 and WIDTH=32.
module tb_pipelined_shift_unit;
    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipelined_shift_unit_if #(.WIDTH(8),  .AMT_W(8)) bus8 ();
    pipelined_shift_unit_if #(.WIDTH(32), .AMT_W(8)) bus32 ();

    pipelined_shift_unit #(.WIDTH(8), .AMT_W(8)) dut8 (
        .CLK    (CLK),
        .RESET  (RESET),
        .bus_io (bus8)
    );

    pipelined_shift_unit #(.WIDTH(32), .AMT_W(8)) dut32 (
        .CLK    (CLK),
        .RESET  (RESET),
        .bus_io (bus32)
    );

    always #5 CLK = ~CLK;

    // Reference: shift rules stated arithmetically on a w-bit value.
    function automatic logic [63:0] ref_shift(input int w, input logic [63:0] d_in,
                                              input int amt, input logic [1:0] mode);
        logic [63:0] mask, d, r;
        logic        sign;
        int          n;
        mask = (64'd1 << w) - 64'd1;
        d    = d_in & mask;
        sign = d[w-1];
        case (mode)
            2'b00:   r = (amt >= w) ? 64'd0 : (d << amt);
            2'b01:   r = (amt >= w) ? 64'd0 : (d >> amt);
            2'b10:   r = (amt >= w) ? (sign ? mask : 64'd0)
                                    : ((d >> amt) | (sign ? (mask & ~(mask >> amt)) : 64'd0));
            default: begin
                n = amt % w;
                r = (n == 0) ? d : ((d >> n) | (d << (w - n)));
            end
        endcase
        return r & mask;
    endfunction

    task automatic idle_all();
        bus8.in_valid   = 1'b0;
        bus8.in_data    = 8'($urandom);
        bus8.in_amt     = 8'($urandom);
        bus8.in_mode    = 2'($urandom);
        bus8.out_ready  = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_data   = $urandom;
        bus32.in_amt    = 8'($urandom);
        bus32.in_mode   = 2'($urandom);
        bus32.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        RESET = 1'b0;
        #12;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.out_data !== 8'h00 || bus8.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset8 valid=%b data=%h zero=%b want 0/00/0",
                     bus8.out_valid, bus8.out_data, bus8.out_zero);
        end
        checks++;
        if (bus32.out_valid !== 1'b0 || bus32.out_data !== 32'h0 || bus32.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset32 valid=%b data=%h zero=%b want 0/0/0",
                     bus32.out_valid, bus32.out_data, bus32.out_zero);
        end
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus8.in_ready !== 1'b1 || bus32.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b/%b want 1/1", bus8.in_ready, bus32.in_ready);
        end
    endtask

    // Four modes then amount 0 in each mode, back-to-back; result expected 3 cycles later.
    task automatic test_modes();
        logic [7:0] din  [8];
        logic [7:0] amt  [8];
        logic [1:0] md   [8];
        logic [7:0] want [8];
        din  = '{8'h81, 8'h81, 8'h90, 8'h81, 8'h5A, 8'hA5, 8'h96, 8'h3C};
        amt  = '{8'd1, 8'd1, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        md   = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        want = '{8'h02, 8'h40, 8'hE4, 8'hC0, 8'h5A, 8'hA5, 8'h96, 8'h3C};
        for (int t = 0; t <= 12; t++) begin
            @(negedge CLK);
            if (t >= 1) begin
                checks++;
                if (t >= 4 && t - 4 < 8) begin
                    if (bus8.out_valid !== 1'b1 || bus8.out_data !== want[t-4]
                        || bus8.out_zero !== (want[t-4] == 8'h00)) begin
                        errors++;
                        $display("FAIL modes[%0d] valid=%b data=%h zero=%b want 1/%h/%b", t - 4,
                                 bus8.out_valid, bus8.out_data, bus8.out_zero, want[t-4],
                                 want[t-4] == 8'h00);
                    end
                end else if (bus8.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL modes_idle t=%0d valid=%b want 0", t, bus8.out_valid);
                end
            end
            if (t < 8) begin
                bus8.in_valid = 1'b1;
                bus8.in_data  = din[t];
                bus8.in_amt   = amt[t];
                bus8.in_mode  = md[t];
            end else begin
                bus8.in_valid = 1'b0;
                bus8.in_data  = 8'($urandom);
                bus8.in_amt   = 8'($urandom);
            end
        end
    endtask

    task automatic test_over_range();
        logic [7:0] din  [4];
        logic [7:0] amt  [4];
        logic [1:0] md   [4];
        logic [7:0] want [4];
        din  = '{8'h80, 8'h80, 8'hFF, 8'h81};
        amt  = '{8'd9, 8'd200, 8'd8, 8'd9};
        md   = '{2'b01, 2'b10, 2'b00, 2'b11};
        want = '{8'h00, 8'hFF, 8'h00, 8'hC0};
        for (int t = 0; t <= 8; t++) begin
            @(negedge CLK);
            if (t >= 1) begin
                checks++;
                if (t >= 4 && t - 4 < 4) begin
                    if (bus8.out_valid !== 1'b1 || bus8.out_data !== want[t-4]
                        || bus8.out_zero !== (want[t-4] == 8'h00)) begin
                        errors++;
                        $display("FAIL over[%0d] valid=%b data=%h zero=%b want 1/%h/%b", t - 4,
                                 bus8.out_valid, bus8.out_data, bus8.out_zero, want[t-4],
                                 want[t-4] == 8'h00);
                    end
                end else if (bus8.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL over_idle t=%0d valid=%b want 0", t, bus8.out_valid);
                end
            end
            if (t < 4) begin
                bus8.in_valid = 1'b1;
                bus8.in_data  = din[t];
                bus8.in_amt   = amt[t];
                bus8.in_mode  = md[t];
            end else begin
                bus8.in_valid = 1'b0;
                bus8.in_data  = 8'($urandom);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        logic [7:0] din [5];
        logic [7:0] amt [5];
        logic [1:0] md  [5];
        logic [7:0] held = 8'h00;
        logic [7:0] w;
        int  sent = 0, got = 0, hold = 0;
        bit  seen = 1'b0;
        logic exp_ready;
        for (int i = 0; i < 5; i++) begin
            din[i] = 8'($urandom);
            amt[i] = 8'($urandom_range(1, 7));
            md[i]  = 2'($urandom);
        end
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            @(negedge CLK);
            if (bus8.out_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                hold = 4;
            end
            if (hold > 0) begin
                bus8.out_ready = 1'b0;
                if (hold == 4) begin
                    held = bus8.out_data;
                end else begin
                    checks++;
                    if (bus8.out_valid !== 1'b1 || bus8.out_data !== held) begin
                        errors++;
                        $display("FAIL bp_hold valid=%b data=%h want 1/%h",
                                 bus8.out_valid, bus8.out_data, held);
                    end
                end
                hold--;
            end else begin
                bus8.out_ready = 1'b1;
            end
            #1;
            exp_ready = !(bus8.out_valid && !bus8.out_ready);
            checks++;
            if (bus8.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL bp_in_ready got %b want %b", bus8.in_ready, exp_ready);
            end
            if (bus8.out_valid === 1'b1 && bus8.out_ready) begin
                checks++;
                w = (q.size() > 0) ? q.pop_front() : 8'hxx;
                if (bus8.out_data !== w) begin
                    errors++;
                    $display("FAIL bp_data[%0d] got %h want %h", got, bus8.out_data, w);
                end
                got++;
            end
            if (sent < 5) begin
                bus8.in_valid = 1'b1;
                bus8.in_data  = din[sent];
                bus8.in_amt   = amt[sent];
                bus8.in_mode  = md[sent];
                if (exp_ready) begin
                    q.push_back(8'(ref_shift(8, {56'd0, din[sent]}, int'(amt[sent]), md[sent])));
                    sent++;
                end
            end else begin
                bus8.in_valid = 1'b0;
            end
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        checks++;
        if (got != 5 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got %0d results (%0d pending) want 5", got, q.size());
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (bus8.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_extra valid=%b want 0", bus8.out_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int t = 0; t < 4; t++) begin
            @(negedge CLK);
            bus8.in_valid = 1'b1;
            bus8.in_data  = 8'($urandom_range(1, 255));
            bus8.in_amt   = 8'd0;
            bus8.in_mode  = 2'b00;
        end
        @(negedge CLK);
        bus8.in_valid = 1'b0;
        checks++;
        if (bus8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre valid=%b want 1", bus8.out_valid);
        end
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.out_data !== 8'h00 || bus8.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_async valid=%b data=%h zero=%b want 0/00/0",
                     bus8.out_valid, bus8.out_data, bus8.out_zero);
        end
        @(negedge CLK);
        RESET = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge CLK);
            checks++;
            if (bus8.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale t=%0d valid=%b want 0", t, bus8.out_valid);
            end
        end
        for (int t = 0; t <= 5; t++) begin
            @(negedge CLK);
            if (t >= 1) begin
                checks++;
                if (t == 4) begin
                    if (bus8.out_valid !== 1'b1 || bus8.out_data !== 8'h80) begin
                        errors++;
                        $display("FAIL rst_after valid=%b data=%h want 1/80",
                                 bus8.out_valid, bus8.out_data);
                    end
                end else if (bus8.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_after_idle t=%0d valid=%b want 0", t, bus8.out_valid);
                end
            end
            bus8.in_valid = (t == 0);
            bus8.in_data  = (t == 0) ? 8'h01 : 8'($urandom);
            bus8.in_amt   = (t == 0) ? 8'd7 : 8'($urandom);
            bus8.in_mode  = (t == 0) ? 2'b00 : 2'($urandom);
        end
    endtask

    // WIDTH=32: directed results with 5-cycle latency.
    task automatic test_width32();
        logic [31:0] din  [2];
        logic [7:0]  amt  [2];
        logic [1:0]  md   [2];
        logic [31:0] want [2];
        din  = '{32'h8000_0000, 32'h0000_0001};
        amt  = '{8'd31, 8'd4};
        md   = '{2'b10, 2'b11};
        want = '{32'hFFFF_FFFF, 32'h1000_0000};
        for (int t = 0; t <= 8; t++) begin
            @(negedge CLK);
            if (t >= 1) begin
                checks++;
                if (t >= 6 && t - 6 < 2) begin
                    if (bus32.out_valid !== 1'b1 || bus32.out_data !== want[t-6]) begin
                        errors++;
                        $display("FAIL w32[%0d] valid=%b data=%h want 1/%h", t - 6,
                                 bus32.out_valid, bus32.out_data, want[t-6]);
                    end
                end else if (bus32.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL w32_latency t=%0d valid=%b want 0", t, bus32.out_valid);
                end
            end
            if (t < 2) begin
                bus32.in_valid = 1'b1;
                bus32.in_data  = din[t];
                bus32.in_amt   = amt[t];
                bus32.in_mode  = md[t];
            end else begin
                bus32.in_valid = 1'b0;
                bus32.in_data  = $urandom;
            end
        end
    endtask

    task automatic test_random32();
        localparam int NOps = 10000;
        logic [31:0] q[$];
        logic [31:0] w;
        logic [31:0] prev_data = 32'h0;
        bit   prev_stall = 1'b0;
        bit   pending = 1'b0;
        int   sent = 0, got = 0;
        logic exp_ready;
        for (int cyc = 0; cyc < 40000 && got < NOps; cyc++) begin
            @(negedge CLK);
            if (prev_stall) begin
                checks++;
                if (bus32.out_valid !== 1'b1 || bus32.out_data !== prev_data) begin
                    errors++;
                    $display("FAIL rnd_stall valid=%b data=%h want 1/%h",
                             bus32.out_valid, bus32.out_data, prev_data);
                end
            end
            bus32.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = !(bus32.out_valid && !bus32.out_ready);
            checks++;
            if (bus32.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_in_ready got %b want %b", bus32.in_ready, exp_ready);
            end
            if (bus32.out_valid === 1'b1 && bus32.out_ready) begin
                checks++;
                w = (q.size() > 0) ? q.pop_front() : 32'hxxxx_xxxx;
                if (bus32.out_data !== w || bus32.out_zero !== (w == 32'h0)) begin
                    errors++;
                    $display("FAIL rnd_data[%0d] got %h zero=%b want %h", got,
                             bus32.out_data, bus32.out_zero, w);
                end
                got++;
            end
            prev_stall = !exp_ready;
            prev_data  = bus32.out_data;
            if (!pending) begin
                if (sent < NOps && $urandom_range(0, 4) != 0) begin
                    pending        = 1'b1;
                    bus32.in_valid = 1'b1;
                    bus32.in_data  = $urandom;
                    bus32.in_amt   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31))
                                                                 : 8'($urandom);
                    bus32.in_mode  = 2'($urandom);
                end else begin
                    bus32.in_valid = 1'b0;
                    bus32.in_data  = $urandom;
                    bus32.in_amt   = 8'($urandom);
                end
            end
            if (pending && exp_ready) begin
                q.push_back(32'(ref_shift(32, {32'd0, bus32.in_data}, int'(bus32.in_amt),
                                          bus32.in_mode)));
                sent++;
                pending = 1'b0;
            end
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        checks++;
        if (got != NOps || q.size() != 0) begin
            errors++;
            $display("FAIL rnd_count got %0d results (%0d pending) want %0d", got, q.size(),
                     NOps);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_over_range();
        test_backpressure();
        test_reset_midflight();
        test_width32();
        test_random32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
